video_stream_monitor: RTL

Parametrised video-stream measurement stage that sits inline on the camera-to-display pixel path. Video passes through with a fixed one-cycle latency. The block measures active width, height, line-width consistency, frames per gate window and protocol errors. Results go to a selectable debug word for the 7-segment/debug display path.

---
 rtl/video_stream_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/video_stream_monitor.sv
// Inline video measurement stage: registered 1-cycle passthrough plus width/height,
// line-consistency, FPS and orphan-line monitoring with a selectable debug word.
module video_stream_monitor #(
   parameter int COLOR_W     = 8,
   parameter int CNT_W       = 12,
   parameter int GATE_CYCLES = 25000000,
   parameter int FPS_W       = 8,
   parameter int DEBUG_W     = 24
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [COLOR_W-1:0] iR,
   input  logic [COLOR_W-1:0] iG,
   input  logic [COLOR_W-1:0] iB,
   input  logic               iHSync,
   input  logic               iVSync,
   input  logic               iLineValid,
   input  logic               iFrameValid,
   input  logic [1:0]         iSel,
   input  logic               iClear,
   output logic [COLOR_W-1:0] oR,
   output logic [COLOR_W-1:0] oG,
   output logic [COLOR_W-1:0] oB,
   output logic               oHSync,
   output logic               oVSync,
   output logic               oLineValid,
   output logic               oFrameValid,
   output logic [CNT_W-1:0]   oWidth,
   output logic [CNT_W-1:0]   oHeight,
   output logic               oStable,
   output logic               oFrameDone,
   output logic [FPS_W-1:0]   oFps,
   output logic               oErrOrphan,
   output logic [DEBUG_W-1:0] oDebug
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [FPS_W-1:0]  FPS_MAX   = '1;

   logic               rLineValidL, rFrameValidL;
   logic [CNT_W-1:0]   pixCnt, lineCnt, refWidth;
   logic               mismatch, haveRef;
   logic [GATE_W-1:0]  gateCnt;
   logic [FPS_W-1:0]   winCnt, winInc, frameCnt;
   logic               lineEnd, frameEnd, frameStart;
   logic [CNT_W-1:0]   lineCntNxt, refNxt;
   logic               mismatchNxt, haveRefNxt;

   assign lineEnd    = rLineValidL & ~iLineValid & rFrameValidL;
   assign frameEnd   = rFrameValidL & ~iFrameValid;
   assign frameStart = ~rFrameValidL & iFrameValid;
   assign winInc     = (frameEnd && winCnt != FPS_MAX) ? winCnt + 1'b1 : winCnt;

   // Line bookkeeping is resolved first so a line closing on the frame-end cycle is latched too.
   always_comb begin
      lineCntNxt  = lineCnt;
      refNxt      = refWidth;
      mismatchNxt = mismatch;
      haveRefNxt  = haveRef;
      if (lineEnd) begin
         if (lineCnt != CNT_MAX) lineCntNxt = lineCnt + 1'b1;
         if (!haveRef) begin
            refNxt     = pixCnt;
            haveRefNxt = 1'b1;
         end else if (pixCnt != refWidth) begin
            mismatchNxt = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         {oR, oG, oB}                                  <= '0;
         {oHSync, oVSync, oLineValid, oFrameValid}     <= '0;
         {rLineValidL, rFrameValidL}                   <= '0;
      end else begin
         oR          <= iR;
         oG          <= iG;
         oB          <= iB;
         oHSync      <= iHSync;
         oVSync      <= iVSync;
         oLineValid  <= iLineValid;
         oFrameValid <= iFrameValid;
         rLineValidL  <= iLineValid;
         rFrameValidL <= iFrameValid;
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         pixCnt     <= '0;
         lineCnt    <= '0;
         refWidth   <= '0;
         mismatch   <= 1'b0;
         haveRef    <= 1'b0;
         oWidth     <= '0;
         oHeight    <= '0;
         oStable    <= 1'b0;
         oFrameDone <= 1'b0;
         frameCnt   <= '0;
         oErrOrphan <= 1'b0;
      end else begin
         if (iLineValid && iFrameValid) begin
            if (!rLineValidL)          pixCnt <= CNT_W'(1);
            else if (pixCnt != CNT_MAX) pixCnt <= pixCnt + 1'b1;
         end
         refWidth   <= refNxt;
         oFrameDone <= frameEnd;
         if (frameEnd) begin
            oWidth  <= refNxt;
            oHeight <= lineCntNxt;
            oStable <= (lineCntNxt != '0) && !mismatchNxt;
         end
         // A rising frame-valid discards any partial frame left over.
         if (frameEnd || frameStart) begin
            lineCnt  <= '0;
            mismatch <= 1'b0;
            haveRef  <= 1'b0;
         end else begin
            lineCnt  <= lineCntNxt;
            mismatch <= mismatchNxt;
            haveRef  <= haveRefNxt;
         end
         if (iClear)        frameCnt <= '0;
         else if (frameEnd) frameCnt <= frameCnt + 1'b1;
         oErrOrphan <= (oErrOrphan & ~iClear) | (iLineValid & ~iFrameValid);
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         gateCnt <= '0;
         winCnt  <= '0;
         oFps    <= '0;
      end else if (gateCnt == GATE_LAST) begin
         gateCnt <= '0;
         winCnt  <= '0;
         oFps    <= winInc;
      end else begin
         gateCnt <= gateCnt + 1'b1;
         winCnt  <= winInc;
      end
   end

   always_comb begin
      oDebug = '0;
      case (iSel)
         2'd0:    oDebug = DEBUG_W'({oWidth, oHeight});
         2'd1:    oDebug = DEBUG_W'(oFps);
         2'd2:    oDebug = DEBUG_W'(frameCnt);
         default: oDebug = DEBUG_W'({oErrOrphan, oStable});
      endcase
   end

endmodule
